pe_weight_rx: RTL and testbench

- PE-side receiver for filter-row weight packets that the filter memory sends over the router.
- Accepts router packets addressed to this PE. Unpacks a 3-weight packet followed by a 2-weight packet into a 5-entry weight register file.
- Flags the row as loaded and serves weights to the PE MAC datapath through a 1-cycle read port.
- Also decodes the timestep-done opcode into a pulse.

---
 rtl/pm_pkt_pkg.sv | 33 +++
 rtl/pe_weight_rx_pkt_decode.sv | 32 +++
 rtl/pe_weight_rx.sv | 118 +++++++++++
 tb/tb_pe_weight_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pm_pkt_pkg.sv
// Router packet format shared by the filter memory and PE-side receivers:
// field positions, opcodes, weight width and the packed packet struct.
package pm_pkt_pkg;

    localparam int unsigned PKT_WIDTH    = 33;
    localparam int unsigned ADDR_MSB     = 32;
    localparam int unsigned ADDR_LSB     = 29;
    localparam int unsigned OPCODE_MSB   = 28;
    localparam int unsigned OPCODE_LSB   = 25;
    localparam int unsigned DATA_MSB     = 24;
    localparam int unsigned DATA_LSB     = 0;
    localparam int unsigned ADDR_WIDTH   = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned DATA_WIDTH   = DATA_MSB - DATA_LSB + 1;
    localparam int unsigned WEIGHT_WIDTH = 8;

    localparam logic [OPCODE_WIDTH-1:0] OP_WEIGHT        = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_TIMESTEP_DONE = 4'd15;

    // Declaration order matches the bit layout: addr occupies the MSBs.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0]   data;
    } pkt_t;

    typedef enum logic [1:0] {
        EXP_FIRST  = 2'd0,
        EXP_SECOND = 2'd1,
        LOADED     = 2'd2
    } rx_state_e;

endpackage

// File: rtl/pe_weight_rx_pkt_decode.sv
// Combinational router packet classifier: address match against this PE and
// opcode decode into weight / timestep-done / drop.
module pkt_decode
    import pm_pkt_pkg::*;
#(
    parameter logic [3:0] PE_ID = 4'd5
) (
    input  pkt_t pkt,
    output logic is_weight,
    output logic is_ts_done,
    output logic is_err
);

    logic addr_match;

    always_comb begin
        addr_match = (pkt.addr == PE_ID);
        is_weight  = 1'b0;
        is_ts_done = 1'b0;
        is_err     = 1'b0;
        if (!addr_match) begin
            is_err = 1'b1;
        end else begin
            unique case (pkt.opcode)
                OP_WEIGHT:        is_weight  = 1'b1;
                OP_TIMESTEP_DONE: is_ts_done = 1'b1;
                default:          is_err     = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pe_weight_rx.sv
// PE-side filter-row weight receiver: unpacks a 3+2 weight packet pair into a
// 5-entry register file with a 1-cycle read port. Optional error counter and
// sequence-error pulse are enabled by defining PE_WEIGHT_RX_ERR_CNT_EN.
module pe_weight_rx #(
    parameter logic [3:0]  PE_ID        = 4'd5,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ROW_LEN      = 5,
    parameter int unsigned PKT_WIDTH    = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PKT_WIDTH-1:0]    in_packet,
    input  logic [2:0]              rd_addr,
    output logic [WEIGHT_WIDTH-1:0] rd_data,
    output logic                    weights_valid,
    output logic                    ts_done,
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
    output logic [7:0]              err_cnt,
    output logic                    seq_err,
`endif
    output logic                    pkt_err
);

    import pm_pkt_pkg::*;

    localparam int unsigned FIRST_CNT  = 3;
    localparam int unsigned SECOND_CNT = ROW_LEN - FIRST_CNT;

    pkt_t                    pkt;
    logic                    accept;
    logic                    is_weight;
    logic                    is_ts_done;
    logic                    is_err;
    rx_state_e               state;
    logic [WEIGHT_WIDTH-1:0] w_q [ROW_LEN];
    logic [WEIGHT_WIDTH-1:0] rd_next;

    assign pkt    = in_packet;
    assign accept = in_valid && in_ready;

    pkt_decode #(
        .PE_ID (PE_ID)
    ) u_decode (
        .pkt        (pkt),
        .is_weight  (is_weight),
        .is_ts_done (is_ts_done),
        .is_err     (is_err)
    );

    // Out-of-range indices (5..7) fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < ROW_LEN; i++) begin
            if (rd_addr == i[2:0]) begin
                rd_next = w_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready      <= 1'b0;
            weights_valid <= 1'b0;
            ts_done       <= 1'b0;
            pkt_err       <= 1'b0;
            rd_data       <= '0;
            state         <= EXP_FIRST;
            for (int unsigned i = 0; i < ROW_LEN; i++) begin
                w_q[i] <= '0;
            end
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
            err_cnt       <= '0;
            seq_err       <= 1'b0;
`endif
        end else begin
            in_ready <= 1'b1;
            ts_done  <= 1'b0;
            pkt_err  <= 1'b0;
            rd_data  <= rd_next;
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
            seq_err  <= 1'b0;
`endif
            if (accept) begin
                if (is_err) begin
                    pkt_err <= 1'b1;
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
`endif
                end else if (is_ts_done) begin
                    ts_done <= 1'b1;
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
                    seq_err <= (state == EXP_SECOND);
`endif
                end else if (is_weight) begin
                    // LOADED behaves like EXP_FIRST: a weight packet restarts the row.
                    if (state == EXP_SECOND) begin
                        for (int unsigned i = 0; i < SECOND_CNT; i++) begin
                            w_q[FIRST_CNT+i] <= pkt.data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        end
                        weights_valid <= 1'b1;
                        state         <= LOADED;
                    end else begin
                        for (int unsigned i = 0; i < FIRST_CNT; i++) begin
                            w_q[i] <= pkt.data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        end
                        weights_valid <= 1'b0;
                        state         <= EXP_SECOND;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_weight_rx.sv
// Directed self-checking bench for pe_weight_rx; also exercises the error
// counter and sequence-error outputs when PE_WEIGHT_RX_ERR_CNT_EN is defined.
module tb_pe_weight_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_packet;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        weights_valid;
    logic        ts_done;
    logic        pkt_err;
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic        seq_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pe_weight_rx #(
        .PE_ID        (4'd5),
        .WEIGHT_WIDTH (8),
        .ROW_LEN      (5),
        .PKT_WIDTH    (33)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_packet     (in_packet),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .weights_valid (weights_valid),
        .ts_done       (ts_done),
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
        .err_cnt       (err_cnt),
        .seq_err       (seq_err),
`endif
        .pkt_err       (pkt_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one packet for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] addr, input logic [3:0] op, input logic [24:0] data);
        in_packet = {addr, op, data};
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        rd_addr   = 3'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wv", {31'd0, weights_valid}, 32'd0);
        check("rst_ts_done", {31'd0, ts_done}, 32'd0);
        check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Foreign address in EXP_FIRST: dropped, single pulse.
        send(4'd6, 4'd0, 25'h0AAAAAA);
        check("foreign_pkt_err", {31'd0, pkt_err}, 32'd1);
        idle();
        check("foreign_pkt_err_end", {31'd0, pkt_err}, 32'd0);
        read_chk("foreign_w0", 3'd0, 8'h00);

        // Basic load, back-to-back packets.
        send(4'd5, 4'd0, 25'h0030201);
        check("load1_wv", {31'd0, weights_valid}, 32'd0);
        send(4'd5, 4'd0, 25'h0000504);
        check("load2_wv", {31'd0, weights_valid}, 32'd1);
        read_chk("load_w0", 3'd0, 8'h01);
        read_chk("load_w1", 3'd1, 8'h02);
        read_chk("load_w2", 3'd2, 8'h03);
        read_chk("load_w3", 3'd3, 8'h04);
        read_chk("load_w4", 3'd4, 8'h05);
        read_chk("load_w5", 3'd5, 8'h00);
        read_chk("load_w7", 3'd7, 8'h00);

        // Reload; second packet carries junk in data[24:16].
        send(4'd5, 4'd0, 25'h10A0B0C);
        check("reload1_wv", {31'd0, weights_valid}, 32'd0);
        read_chk("reload_w0", 3'd0, 8'h0C);
        read_chk("reload_w2", 3'd2, 8'h0A);
        read_chk("reload_w3_old", 3'd3, 8'h04);
        // Foreign packet between the pair must not disturb EXP_SECOND.
        send(4'd3, 4'd0, 25'h0001111);
        check("mid_foreign_pkt_err", {31'd0, pkt_err}, 32'd1);
        send(4'd5, 4'd0, 25'h1FF0E0D);
        check("reload2_wv", {31'd0, weights_valid}, 32'd1);
        read_chk("reload_w3", 3'd3, 8'h0D);
        read_chk("reload_w4", 3'd4, 8'h0E);

        // Timestep done in LOADED, then an unknown opcode.
        send(4'd5, 4'd15, 25'h0);
        check("ts_pulse", {31'd0, ts_done}, 32'd1);
        check("ts_wv", {31'd0, weights_valid}, 32'd1);
        idle();
        check("ts_pulse_end", {31'd0, ts_done}, 32'd0);
        send(4'd5, 4'd7, 25'h0);
        check("op7_pkt_err", {31'd0, pkt_err}, 32'd1);
        check("op7_ts_done", {31'd0, ts_done}, 32'd0);
        read_chk("op7_w1", 3'd1, 8'h0B);
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
        check("err_cnt_3", {24'd0, err_cnt}, 32'd3);
`endif

        // Reset mid-load with a simultaneous packet.
        send(4'd5, 4'd0, 25'h0223344);
        check("midload_wv", {31'd0, weights_valid}, 32'd0);
        rst       = 1'b1;
        in_packet = {4'd5, 4'd0, 25'h0005566};
        in_valid  = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_wv", {31'd0, weights_valid}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        read_chk("midrst_w0", 3'd0, 8'h00);
        read_chk("midrst_w3", 3'd3, 8'h00);
        read_chk("midrst_w4", 3'd4, 8'h00);
        send(4'd5, 4'd0, 25'h0090807);
        send(4'd5, 4'd0, 25'h0000B0A);
        check("fresh_wv", {31'd0, weights_valid}, 32'd1);
        read_chk("fresh_w0", 3'd0, 8'h07);
        read_chk("fresh_w2", 3'd2, 8'h09);
        read_chk("fresh_w4", 3'd4, 8'h0B);

        // Timestep done while waiting for the second packet.
        send(4'd5, 4'd0, 25'h0030201);
        send(4'd5, 4'd15, 25'h0);
        check("ts_exp2_pulse", {31'd0, ts_done}, 32'd1);
        check("ts_exp2_wv", {31'd0, weights_valid}, 32'd0);
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
        check("seq_err_pulse", {31'd0, seq_err}, 32'd1);
`endif
        send(4'd5, 4'd0, 25'h0000504);
        check("ts_exp2_after_wv", {31'd0, weights_valid}, 32'd1);
`ifdef PE_WEIGHT_RX_ERR_CNT_EN
        check("seq_err_end", {31'd0, seq_err}, 32'd0);
`endif
        read_chk("ts_exp2_w4", 3'd4, 8'h05);

`ifdef PE_WEIGHT_RX_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            send(4'd9, 4'd0, 25'h0);
        end
        idle();
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
